// File: rtl/i2c_pkg.sv
// Shared types and constants for the Avalon-MM I2C command queue.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_e;

  // One queued transfer: bus condition flags plus the byte to send.
  typedef struct packed {
    logic       start;
    logic       wr;
    logic       ack;
    logic       stop;
    logic [7:0] data;
  } cmd_entry_t;

  localparam logic [2:0] ADR_CTRL    = 3'd0;
  localparam logic [2:0] ADR_IRQ     = 3'd1;
  localparam logic [2:0] ADR_DATA    = 3'd2;
  localparam logic [2:0] ADR_CMD     = 3'd3;
  localparam logic [2:0] ADR_CMD_LVL = 3'd4;
  localparam logic [2:0] ADR_RX_LVL  = 3'd5;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/i2c_fifo.sv
// Synchronous FIFO with occupancy output and single-cycle flush.
// A push while full is taken only when a pop frees the head slot in the same cycle.
module i2c_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign level   = wptr_q - rptr_q;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata   = mem_q[rptr_q[AW-1:0]];
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Pointer and storage next-state; flush overrides any push/pop.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q[AW-1:0]] = wdata;
        wptr_d = wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/i2c_avs_queue.sv
// Avalon-MM front end that queues I2C byte commands and sequences them to the core.
//
//   state    | meaning
//   ST_IDLE  | waiting for enabled, non-empty, error-free queue
//   ST_ISSUE | load head entry onto core outputs, pulse cmdBegin, pop
//   ST_WAIT  | transfer in flight, waiting for cmdRdy
module i2c_avs_queue
  import i2c_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] avsAdr,
  input  logic       avsWr,
  input  logic [7:0] avsWrData,
  input  logic       avsRd,
  output logic [7:0] avsRdData,
  output logic       insIrq,
  output logic       cmdBegin,
  output logic       cmdClear,
  output logic       cmdBitStart,
  output logic       cmdBitWr,
  output logic       cmdBitAck,
  output logic       cmdBitStop,
  output logic [7:0] cmdByteWr,
  input  logic       cmdRdy,
  input  logic [7:0] cmdByteRd,
  input  logic [1:0] cmdErr,
  input  logic       cmdBusy,
  input  logic       cmdWait
);

  localparam int LW = $clog2(DEPTH) + 1;

  seq_state_e state_q, state_d;
  cmd_entry_t issued_q, issued_d;
  logic       mod_en_q, mod_en_d, irq_en_q, irq_en_d;
  logic [7:0] stage_q, stage_d, rd_data_q, rd_data_d;
  logic [3:0] status_q, status_d;
  logic       err_latched_q, err_latched_d;
  logic [1:0] last_err_q, last_err_d;
  logic       cmd_begin_q, cmd_begin_d, cmd_clear_q, cmd_clear_d;

  logic          wr_ctrl, wr_irq, wr_data, wr_cmd, soft_rst, clear_evt;
  logic          cmd_push, cmd_pop, cmd_flush, cmd_full, cmd_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [LW-1:0] cmd_level, rx_level;
  logic [11:0]   cmd_head_raw;
  cmd_entry_t    cmd_head;
  logic [7:0]    rx_head;
  logic          seq_done, seq_err, rx_ovf_set, cmd_ovf_set;

  assign wr_ctrl   = avsWr && (avsAdr == ADR_CTRL);
  assign wr_irq    = avsWr && (avsAdr == ADR_IRQ);
  assign wr_data   = avsWr && (avsAdr == ADR_DATA);
  assign wr_cmd    = avsWr && (avsAdr == ADR_CMD);
  assign soft_rst  = wr_ctrl & avsWrData[0];
  assign clear_evt = wr_ctrl & (~avsWrData[7] | avsWrData[0]);
  assign cmd_head  = cmd_entry_t'(cmd_head_raw);

  i2c_fifo #(.WIDTH(12), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (cmd_flush),
    .push  (cmd_push),
    .wdata ({avsWrData[7:4], stage_q}),
    .pop   (cmd_pop),
    .rdata (cmd_head_raw),
    .full  (cmd_full),
    .empty (cmd_empty),
    .level (cmd_level)
  );

  i2c_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear_evt),
    .push  (rx_push),
    .wdata (cmdByteRd),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  // Sequencer: issue one queued entry at a time and collect its completion.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    cmd_begin_d = 1'b0;
    cmd_pop     = 1'b0;
    rx_push     = 1'b0;
    seq_done    = 1'b0;
    seq_err     = 1'b0;
    last_err_d  = last_err_q;
    case (state_q)
      ST_IDLE: begin
        if (mod_en_q && !cmd_empty && !err_latched_q) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        issued_d    = cmd_head;
        cmd_begin_d = 1'b1;
        cmd_pop     = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmdRdy) begin
          last_err_d = cmdErr;
          state_d    = ST_IDLE;
          if (cmdErr != ERR_OK) begin
            seq_err = 1'b1;
          end else begin
            rx_push  = ~issued_q.wr;
            seq_done = cmd_empty;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A clear abandons whatever the sequencer was doing this cycle.
    if (clear_evt) begin
      state_d     = ST_IDLE;
      issued_d    = issued_q;
      cmd_begin_d = 1'b0;
      cmd_pop     = 1'b0;
      rx_push     = 1'b0;
      seq_done    = 1'b0;
      seq_err     = 1'b0;
      last_err_d  = ERR_OK;
    end
  end

  // Register file: control, sticky status, staged byte, command push and read mux.
  always_comb begin
    mod_en_d      = mod_en_q;
    irq_en_d      = irq_en_q;
    stage_d       = stage_q;
    rd_data_d     = rd_data_q;
    cmd_clear_d   = clear_evt;
    cmd_push      = wr_cmd & ~cmd_full;
    cmd_ovf_set   = wr_cmd & cmd_full;
    cmd_flush     = clear_evt | seq_err;
    rx_pop        = avsRd && (avsAdr == ADR_DATA) && !rx_empty;
    rx_ovf_set    = rx_push & rx_full & ~rx_pop;
    status_d      = (status_q & ~(wr_irq ? avsWrData[3:0] : 4'h0))
                  | {cmd_ovf_set, rx_ovf_set, seq_err, seq_done};
    err_latched_d = (err_latched_q & ~(wr_irq & avsWrData[1])) | seq_err;
    if (wr_ctrl) begin
      mod_en_d = avsWrData[7];
      irq_en_d = avsWrData[6];
    end
    if (wr_data) stage_d = avsWrData;
    if (clear_evt) begin
      status_d      = 4'h0;
      err_latched_d = 1'b0;
      if (soft_rst) begin
        mod_en_d = 1'b0;
        irq_en_d = 1'b0;
        stage_d  = 8'h00;
      end
    end
    if (avsRd) begin
      case (avsAdr)
        ADR_CTRL:    rd_data_d = {mod_en_q, irq_en_q, 6'b0};
        ADR_IRQ:     rd_data_d = {4'b0, status_q};
        ADR_DATA:    rd_data_d = rx_empty ? 8'h00 : rx_head;
        ADR_CMD:     rd_data_d = {cmdBusy, cmdWait, cmd_full, rx_empty,
                                  err_latched_q, 1'b0, last_err_q};
        ADR_CMD_LVL: rd_data_d = 8'(cmd_level);
        ADR_RX_LVL:  rd_data_d = 8'(rx_level);
        default:     rd_data_d = 8'h00;
      endcase
    end
  end

  // All state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      issued_q      <= '0;
      mod_en_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      stage_q       <= 8'h00;
      rd_data_q     <= 8'h00;
      status_q      <= 4'h0;
      err_latched_q <= 1'b0;
      last_err_q    <= ERR_OK;
      cmd_begin_q   <= 1'b0;
      cmd_clear_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      mod_en_q      <= mod_en_d;
      irq_en_q      <= irq_en_d;
      stage_q       <= stage_d;
      rd_data_q     <= rd_data_d;
      status_q      <= status_d;
      err_latched_q <= err_latched_d;
      last_err_q    <= last_err_d;
      cmd_begin_q   <= cmd_begin_d;
      cmd_clear_q   <= cmd_clear_d;
    end
  end

  assign avsRdData   = rd_data_q;
  assign insIrq      = mod_en_q & irq_en_q & (|status_q);
  assign cmdBegin    = cmd_begin_q;
  assign cmdClear    = cmd_clear_q;
  assign cmdBitStart = issued_q.start;
  assign cmdBitWr    = issued_q.wr;
  assign cmdBitAck   = issued_q.ack;
  assign cmdBitStop  = issued_q.stop;
  assign cmdByteWr   = issued_q.data;

endmodule
